// File: rtl/mmu_sequencer.sv
// Job sequencer: loads A/B into the matrix memory, replays them to the 2x2
// multiply array, stores the four results at C and drains them to the host.
module mmu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_write_en,
  output logic [3:0]       mem_write_addr,
  output logic [WIDTH-1:0] mem_data_in,
  output logic             mem_read_en,
  output logic [3:0]       mem_read_addr,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic             op_valid,
  output logic [2:0]       op_index,
  output logic [WIDTH-1:0] op_data,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, LOAD, FETCH, WAIT_RES, DRAIN_RD, DRAIN_HOLD} state_t;

  state_t           state, state_nxt;
  logic [2:0]       load_cnt, fetch_cnt;
  logic [1:0]       res_cnt, out_cnt;
  logic             vld_q, hold_first;
  logic [1:0]       vld_pipe;
  logic [WIDTH-1:0] out_q;

  // Operand valid tracks the FETCH read by one cycle, matching the memory's read latency.
  assign vld_pipe = {vld_q, state == FETCH};
  assign op_valid = vld_pipe[1];
  assign op_data  = vld_pipe[1] ? mem_data_out : '0;
  assign busy     = state != IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      load_cnt   <= '0;
      fetch_cnt  <= '0;
      res_cnt    <= '0;
      out_cnt    <= '0;
      vld_q      <= 1'b0;
      op_index   <= '0;
      hold_first <= 1'b0;
      out_q      <= '0;
    end else begin
      state      <= state_nxt;
      vld_q      <= vld_pipe[0];
      op_index   <= mem_read_addr[2:0];
      hold_first <= state == DRAIN_RD;
      if (state == DRAIN_HOLD && hold_first) out_q <= mem_data_out;
      case (state)
        IDLE:
          if (start) begin
            load_cnt  <= '0;
            fetch_cnt <= '0;
            res_cnt   <= '0;
            out_cnt   <= '0;
          end
        LOAD:       if (in_valid) load_cnt <= load_cnt + 3'd1;
        FETCH:      fetch_cnt <= fetch_cnt + 3'd1;
        WAIT_RES:   if (res_valid) res_cnt <= res_cnt + 2'd1;
        DRAIN_HOLD: if (out_ready && out_cnt != 2'd3) out_cnt <= out_cnt + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    mem_write_en   = 1'b0;
    mem_write_addr = '0;
    mem_data_in    = '0;
    mem_read_en    = 1'b0;
    mem_read_addr  = '0;
    out_valid      = 1'b0;
    out_data       = '0;
    done           = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_write_en   = 1'b1;
          mem_write_addr = {1'b0, load_cnt};
          mem_data_in    = in_data;
          if (load_cnt == 3'd7) state_nxt = FETCH;
        end
      end
      FETCH: begin
        mem_read_en   = 1'b1;
        mem_read_addr = {1'b0, fetch_cnt};
        if (fetch_cnt == 3'd7) state_nxt = WAIT_RES;
      end
      WAIT_RES:
        if (res_valid) begin
          mem_write_en   = 1'b1;
          mem_write_addr = {2'b10, res_cnt};
          mem_data_in    = res_data;
          if (res_cnt == 2'd3) state_nxt = DRAIN_RD;
        end
      DRAIN_RD: begin
        mem_read_en   = 1'b1;
        mem_read_addr = {2'b10, out_cnt};
        state_nxt     = DRAIN_HOLD;
      end
      DRAIN_HOLD: begin
        // Read data is live only in the first hold cycle; afterwards the captured copy holds it.
        out_valid = 1'b1;
        out_data  = hold_first ? mem_data_out : out_q;
        if (out_ready) begin
          if (out_cnt == 2'd3) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = DRAIN_RD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mmu_sequencer.sv
// Randomized bench for mmu_sequencer: models the matrix memory and the 2x2
// array, and checks every phase of a job cycle by cycle.
module tb_mmu_sequencer;
  localparam int WIDTH = 8;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [WIDTH-1:0] in_data = '0, res_data = '0;
  logic             in_valid = 1'b0, res_valid = 1'b0, out_ready = 1'b0;
  logic             in_ready, mem_write_en, mem_read_en, op_valid, out_valid, busy, done;
  logic [3:0]       mem_write_addr, mem_read_addr;
  logic [WIDTH-1:0] mem_data_in, op_data, out_data;
  logic [WIDTH-1:0] mem_data_out = '0;
  logic [2:0]       op_index;

  logic [WIDTH-1:0] mem [16] = '{default: '0};
  logic [7:0]       opnd [8];
  int               c [4];
  int               checks = 0, errors = 0;

  mmu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_data_in(mem_data_in),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr), .mem_data_out(mem_data_out),
    .op_valid(op_valid), .op_index(op_index), .op_data(op_data),
    .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Dual-port memory: synchronous write, registered read returning 0 when idle.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_addr] <= mem_data_in;
    mem_data_out <= mem_read_en ? mem[mem_read_addr] : '0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wen"}, mem_write_en, 0);
    chk({tag, "_waddr"}, mem_write_addr, 0);
    chk({tag, "_ren"}, mem_read_en, 0);
    chk({tag, "_raddr"}, mem_read_addr, 0);
    chk({tag, "_op_valid"}, op_valid, 0);
    chk({tag, "_op_index"}, op_index, 0);
    chk({tag, "_op_data"}, op_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Reference result: C = A * B, 2x2 row-major, truncated to the element width.
  task automatic calc_ref();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++)
        c[r*2+k] = (int'(opnd[r*2]) * int'(opnd[4+k]) + int'(opnd[r*2+1]) * int'(opnd[6+k])) & 8'hff;
  endtask

  task automatic run_job(input int gap_max, input int stall_max, input int resgap_max,
                         input bit hold_start, input int abort_at);
    int g;
    bit first;
    calc_ref();
    start = 1'b1;
    cyc();
    if (!hold_start) start = 1'b0;
    #1;
    chk("load_ready", in_ready, 1);
    chk("load_busy", busy, 1);
    for (int k = 0; k < 8; k++) begin
      g = int'($urandom_range(gap_max, 0));
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        #1;
        chk("load_gap_wen", mem_write_en, 0);
        chk("load_gap_ready", in_ready, 1);
        cyc();
      end
      in_valid = 1'b1;
      in_data  = opnd[k];
      #1;
      chk("load_wen", mem_write_en, 1);
      chk("load_waddr", mem_write_addr, k);
      chk("load_wdata", mem_data_in, opnd[k]);
      cyc();
    end
    // Fetch: eight reads, operands trail by one cycle; host/array noise ignored.
    for (int j = 0; j < 8; j++) begin
      in_valid  = 1'($urandom_range(1, 0));
      in_data   = 8'($urandom);
      res_valid = 1'($urandom_range(1, 0));
      res_data  = 8'($urandom);
      #1;
      chk("fetch_ready", in_ready, 0);
      chk("fetch_wen", mem_write_en, 0);
      chk("fetch_ren", mem_read_en, 1);
      chk("fetch_raddr", mem_read_addr, j);
      chk("fetch_op_valid", op_valid, j > 0);
      if (j > 0) begin
        chk("fetch_op_index", op_index, j - 1);
        chk("fetch_op_data", op_data, opnd[j-1]);
      end
      if (j == abort_at) begin
        rst_n = 1'b0; in_valid = 1'b0; res_valid = 1'b0; start = 1'b0;
        cyc();
        #1;
        chk_idle("abort");
        rst_n = 1'b1;
        cyc();
        return;
      end
      cyc();
    end
    in_valid  = 1'b0;
    res_valid = 1'b0;
    #1;
    chk("last_op_valid", op_valid, 1);
    chk("last_op_index", op_index, 7);
    chk("last_op_data", op_data, opnd[7]);
    first = 1'b1;
    for (int r = 0; r < 4; r++) begin
      g = int'($urandom_range(resgap_max, 0));
      repeat (g) begin
        res_valid = 1'b0;
        in_valid  = 1'($urandom_range(1, 0));
        #1;
        chk("res_gap_wen", mem_write_en, 0);
        cyc();
        if (first) begin chk("op_end", op_valid, 0); first = 1'b0; end
      end
      in_valid  = 1'b0;
      res_valid = 1'b1;
      res_data  = 8'(c[r]);
      #1;
      chk("res_wen", mem_write_en, 1);
      chk("res_waddr", mem_write_addr, 8 + r);
      chk("res_wdata", mem_data_in, c[r]);
      cyc();
      if (first) begin chk("op_end", op_valid, 0); first = 1'b0; end
    end
    res_valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      out_ready = 1'($urandom_range(1, 0));
      #1;
      chk("drain_ren", mem_read_en, 1);
      chk("drain_raddr", mem_read_addr, 8 + r);
      chk("drain_out_valid", out_valid, 0);
      cyc();
      g = int'($urandom_range(stall_max, 0));
      repeat (g) begin
        out_ready = 1'b0;
        #1;
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, c[r]);
        chk("stall_done", done, 0);
        cyc();
      end
      out_ready = 1'b1;
      #1;
      chk("xfer_out_valid", out_valid, 1);
      chk("xfer_out_data", out_data, c[r]);
      chk("xfer_done", done, r == 3);
      cyc();
      out_ready = 1'b0;
    end
    #1;
    chk("end_busy", busy, 0);
    chk("end_done", done, 0);
    chk("end_in_ready", in_ready, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cyc(); cyc();
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'($urandom_range(1, 0));
      in_data   = 8'($urandom);
      res_valid = 1'(i & 1);
      res_data  = 8'($urandom);
      out_ready = 1'($urandom_range(1, 0));
      #1;
      chk_idle("idle");
      cyc();
    end
    in_valid = 1'b0; res_valid = 1'b0; out_ready = 1'b0;

    for (int k = 0; k < 8; k++) opnd[k] = 8'(k + 1);
    run_job(0, 0, 3, 1'b0, -1);

    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 8; k++) opnd[k] = 8'($urandom);
      run_job(3, 5, 3, 1'b0, -1);
    end

    for (int k = 0; k < 8; k++) opnd[k] = 8'($urandom);
    run_job(2, 2, 2, 1'b0, 4);
    for (int k = 0; k < 8; k++) opnd[k] = 8'($urandom);
    run_job(2, 3, 3, 1'b0, -1);

    // Start held high: the second job launches straight from the single IDLE cycle.
    for (int k = 0; k < 8; k++) opnd[k] = 8'($urandom);
    run_job(1, 2, 1, 1'b1, -1);
    chk("held_start", start, 1);
    for (int k = 0; k < 8; k++) opnd[k] = 8'($urandom);
    run_job(1, 2, 1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmu_sequencer.md
# mmu_sequencer

Job sequencer for the 16-entry dual-port matrix memory and the 2×2 matrix-multiply array. Once per job it loads operand matrices A and B from a host byte stream into the memory. It then replays them in a fixed order to the array, writes the four result elements back, and streams the results out to the host. It owns both memory ports; the host and the array never touch the memory directly.

## Interface
- WIDTH, 8, element width; must match the memory.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- start  in  1  begin a job; sampled only in IDLE.
- in_data  in  WIDTH  host operand byte.
- in_valid / in_ready  in / out  1  host load handshake; a transfer occurs when both are high.
- mem_write_en, mem_write_addr[3:0], mem_data_in  out  1/4/WIDTH  memory port A.
- mem_read_en, mem_read_addr[3:0]  out  1/4  memory port B request.
- mem_data_out  in  WIDTH  memory port B data; registered, valid 1 cycle after request, 0 when not requested.
- op_valid, op_index[2:0], op_data[WIDTH-1:0]  out  operand stream to the array.
- res_valid, res_data[WIDTH-1:0]  in  result stream from the array; no backpressure.
- out_valid / out_ready, out_data[WIDTH-1:0]  out / in / out  host result handshake.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last result is accepted.

## Operation
- Address map: {matrix[1:0], element[1:0]}. Matrix 0 = A at 0–3, matrix 1 = B at 4–7, matrix 2 = C at 8–11. Matrix 3 is unused and never accessed. Elements are row-major (e00, e01, e10, e11).
- States: IDLE, LOAD, FETCH, WAIT_RES, DRAIN_RD, DRAIN_HOLD.
- IDLE: start=1 → LOAD. No other input has any effect.
- LOAD:
  - in_ready=1.
  - Each accepted byte drives a combinational write: mem_write_en=1, mem_write_addr=load_cnt, mem_data_in=in_data.
  - load_cnt counts 0..7; the 8th transfer → FETCH.
- FETCH:
  - 8 consecutive cycles with mem_read_en=1 and mem_read_addr=fetch_cnt (0..7).
  - After the cycle with address 7 → WAIT_RES.
- Operand stream:
  - op_valid is the read enable delayed by 1 cycle.
  - op_index is the read address delayed by 1 cycle (low 3 bits).
  - op_data = mem_data_out, passed through combinationally.
  - Index 7 is therefore presented in the first WAIT_RES cycle.
- WAIT_RES:
  - Each res_valid writes res_data to address 8+res_cnt; res_cnt counts 0..3.
  - The 4th result → DRAIN_RD.
  - res_valid is ignored in every other state.
- DRAIN_RD: mem_read_en=1, addr=8+out_cnt → DRAIN_HOLD.
- DRAIN_HOLD:
  - On entry, out_data captures mem_data_out and out_valid=1.
  - out_data and out_valid stay stable until out_ready=1.
  - On transfer: if out_cnt<3, increment and → DRAIN_RD; else pulse done and → IDLE.
- Write port: LOAD and WAIT_RES are disjoint, so there is no write arbitration. Read-port users (FETCH, DRAIN_RD) are also disjoint.
- Counters are 3-bit (load/fetch) and 2-bit (res/out). All are cleared on entry to LOAD.
- The block does not clear memory contents; memory reset is driven by the top level.

## Timing
- Reset (rst_n=0 at an edge):
  - State → IDLE; all counters 0.
  - in_ready, op_valid, out_valid, busy, done, mem_write_en, mem_read_en = 0.
  - out_data, op_index, mem addresses = 0.
  - Applies mid-job too: the job is abandoned, and partial memory writes stay.
- start to in_ready: 1 cycle. start held high in IDLE launches exactly one job.
- Back-to-back host bytes give 1 byte/cycle; the load phase takes 8 cycles at minimum.
- Last load transfer to first op_valid: 2 cycles. The 8 operands are contiguous, one per cycle.
- Drain throughput: 1 result per 2 cycles when out_ready is held high.
- done is high in the same cycle as the final out_valid&&out_ready transfer. The next cycle is IDLE with busy=0.
- start is accepted again in the first IDLE cycle after done.
- res_valid in the first WAIT_RES cycle is accepted.
- in_valid outside LOAD: ignored, no write, in_ready=0.

## Test plan
- Reset, then idle with in_valid=1 and res_valid=1 toggling → no memory writes, busy=0, all outputs 0.
- start, stream A=1,2,3,4 and B=5,6,7,8 back-to-back → writes at addresses 0..7. Then op_index 0..7 with op_data 1..8 on 8 consecutive cycles, starting 2 cycles after the last load.
- Results 19,22,43,50 with 0–3 idle cycles between → writes at 8..11. out_data sequence 19,22,43,50; done coincides with the last transfer.
- Random in_valid gaps and out_ready stalls of up to 5 cycles → in_data order preserved, and out_data/out_valid stable while stalled.
- rst_n low for 1 cycle mid-FETCH, after op_index 3 → all outputs 0 next cycle. A new job with fresh data then completes correctly.
- start held high through a full job → exactly one job per IDLE entry. A second job begins the cycle after done.
